// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// family code, op encodings, FSM states and operand-signedness helpers.
package muldiv_unit_pkg;

    localparam logic [2:0] MULDIV_FAMILY = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Encoded as {aluc[5:4], aluc[3]}; bit 0 set means divide family.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_DIV    = 3'b001,
        OP_MULH   = 3'b010,
        OP_DIVU   = 3'b011,
        OP_MULHSU = 3'b100,
        OP_REM    = 3'b101,
        OP_MULHU  = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    // rs1 is treated as signed for these ops.
    function automatic logic a_is_signed(input op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as signed for these ops.
    function automatic logic b_is_signed(input op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes,
// processed one radix-2 step per cycle for XLEN cycles, then sign-corrected.
// The same {hi, lo} register pair serves as the product accumulator for
// multiplies and as {remainder, quotient} for divides.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic            flush,
    input  logic [5:0]      aluc,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    op_t             op;
    logic            sa, sb;        // operand signs (zero for unsigned operands)
    logic            b_zero, ovf;   // special cases resolved in FIX
    logic [XLEN-1:0] a_raw;         // original rs1, returned by rem on divide-by-zero
    logic [XLEN-1:0] mb;            // |multiplicand| or |divisor|
    logic [XLEN-1:0] hi, lo;

    op_t             op_in;
    logic            accept, sa_in, sb_in;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_val;

    assign op_in  = op_t'({aluc[5:4], aluc[3]});
    assign accept = (state == ST_IDLE) && start && !flush && (aluc[2:0] == MULDIV_FAMILY);
    assign sa_in  = a_is_signed(op_in) & a[XLEN-1];
    assign sb_in  = b_is_signed(op_in) & b[XLEN-1];
    assign abs_a  = sa_in ? -a : a;
    assign abs_b  = sb_in ? -b : b;

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; flush overrides everything and drops a same-cycle start.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_CALC;
            ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mb};
    end

    // Sign correction and field selection; divide special cases override the datapath.
    always_comb begin
        prod    = {hi, lo};
        prod_s  = (sa ^ sb) ? -prod : prod;
        quo_s   = (sa ^ sb) ? -lo : lo;
        rem_s   = sa ? -hi : hi;
        fix_val = prod_s[XLEN-1:0];
        case (op)
            OP_MUL:                     fix_val = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fix_val = b_zero ? {XLEN{1'b1}} : (ovf ? a_raw : quo_s);
            OP_REM, OP_REMU:            fix_val = b_zero ? a_raw : (ovf ? {XLEN{1'b0}} : rem_s);
            default:                    fix_val = prod_s[XLEN-1:0];
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, register result in FIX.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt    <= '0;
            op     <= OP_MUL;
            sa     <= 1'b0;
            sb     <= 1'b0;
            b_zero <= 1'b0;
            ovf    <= 1'b0;
            a_raw  <= '0;
            mb     <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    cnt    <= '0;
                    op     <= op_in;
                    sa     <= sa_in;
                    sb     <= sb_in;
                    b_zero <= (b == '0);
                    ovf    <= (op_in inside {OP_DIV, OP_REM}) && (a == MOST_NEG) && (b == '1);
                    a_raw  <= a;
                    hi     <= '0;
                    // Divide: lo holds |dividend|, mb |divisor|.
                    // Multiply: lo holds |multiplier| (rs2), mb |multiplicand| (rs1).
                    if (op_in[0]) begin
                        lo <= abs_a;
                        mb <= abs_b;
                    end else begin
                        lo <= abs_b;
                        mb <= abs_a;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op[0]) begin
                        if (!div_diff[XLEN]) begin
                            hi <= div_diff[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
                    end
                end
                ST_FIX:  result <= fix_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, randomized
// ops against an arithmetic reference model, flush / reset / busy-start handling.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start, flush;
    logic [5:0]  aluc;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int nchecks = 0;
    int nerrors = 0;

    localparam logic [2:0] MUL = 3'b000, DIV = 3'b001, MULH = 3'b010, DIVU = 3'b011,
                           MULHSU = 3'b100, REM = 3'b101, MULHU = 3'b110, REMU = 3'b111;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .clrn(clrn), .start(start), .flush(flush), .aluc(aluc),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        int ix, iy;
        sx = longint'($signed(x)); sy = longint'($signed(y));
        ux = longint'({32'd0, x}); uy = longint'({32'd0, y});
        ix = $signed(x); iy = $signed(y);
        case (opc)
            MUL:    begin p = sx * sy; return p[31:0];  end
            MULH:   begin p = sx * sy; return p[63:32]; end
            MULHSU: begin p = sx * uy; return p[63:32]; end
            MULHU:  begin p = ux * uy; return p[63:32]; end
            DIV:    if (y == 0) return 32'hFFFF_FFFF;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                    else return 32'(ix / iy);
            DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            REM:    if (y == 0) return x;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                    else return 32'(ix % iy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Drive a request during cycle 0; returns at the sampling point of cycle 1.
    task automatic issue(input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; aluc = {opc[2:1], opc[0], 3'b001}; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle number done was seen in and how many cycles busy was low before it.
    task automatic wait_done(output int cyc, output int gaps);
        cyc = 1; gaps = 0;
        while (!done && cyc < 60) begin
            if (!busy) gaps++;
            @(negedge clk);
            cyc++;
        end
        if (!busy) gaps++;
    endtask

    task automatic run_check(input string tag, input logic [2:0] opc, input logic [31:0] x, input logic [31:0] y);
        int cyc, gaps;
        issue(opc, x, y);
        wait_done(cyc, gaps);
        chk({tag, " latency"}, 64'(cyc), 64'd34);
        chk({tag, " busy"}, 64'(gaps), 64'd0);
        chk(tag, {32'd0, result}, {32'd0, model(opc, x, y)});
        @(negedge clk);
        chk({tag, " idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc, gaps, pulses;
        logic [31:0] old;
        clrn = 1'b0; start = 1'b0; flush = 1'b0; aluc = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset result", {32'd0, result}, 64'd0);
        clrn = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_check("mul 7*-3", MUL, 32'd7, 32'hFFFF_FFFD);
        chk("mul 7*-3 value", {32'd0, result}, 64'h0000_0000_FFFF_FFEB);
        run_check("mulh min*min", MULH, 32'h8000_0000, 32'h8000_0000);
        chk("mulh value", {32'd0, result}, 64'h4000_0000);
        run_check("mulhu max*max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhu value", {32'd0, result}, 64'hFFFF_FFFE);
        run_check("mulhsu -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhsu value", {32'd0, result}, 64'hFFFF_FFFF);
        run_check("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div value", {32'd0, result}, 64'hFFFF_FFFD);
        run_check("rem -7%2", REM, 32'hFFFF_FFF9, 32'd2);
        chk("rem value", {32'd0, result}, 64'hFFFF_FFFF);
        run_check("divu 100/7", DIVU, 32'd100, 32'd7);
        chk("divu value", {32'd0, result}, 64'd14);
        run_check("remu 100%7", REMU, 32'd100, 32'd7);
        chk("remu value", {32'd0, result}, 64'd2);
        run_check("divu 5/0", DIVU, 32'd5, 32'd0);
        chk("divu /0 value", {32'd0, result}, 64'hFFFF_FFFF);
        run_check("remu 5/0", REMU, 32'd5, 32'd0);
        chk("remu /0 value", {32'd0, result}, 64'd5);
        run_check("div -7/0", DIV, 32'hFFFF_FFF9, 32'd0);
        run_check("rem -7/0", REM, 32'hFFFF_FFF9, 32'd0);
        run_check("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div ovf value", {32'd0, result}, 64'h8000_0000);
        run_check("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("rem ovf value", {32'd0, result}, 64'd0);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] opc;
            opc = 3'($urandom_range(0, 7));
            run_check($sformatf("rnd%0d op%0d", i, opc), opc, pick(), pick());
        end

        // Held result: establish a nonzero value first.
        run_check("divu 1000/3", DIVU, 32'd1000, 32'd3);
        old = result;
        repeat (3) @(negedge clk);
        chk("result held", {32'd0, result}, {32'd0, old});

        // Wrong family code: ignored.
        start = 1'b1; aluc = 6'b001_000; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("bad family busy", {63'd0, busy}, 64'd0);

        // Flush and start together in IDLE: start dropped.
        start = 1'b1; flush = 1'b1; aluc = {DIV[2:1], DIV[0], 3'b001};
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", {63'd0, busy}, 64'd0);

        // Flush in cycle 10 of a divide.
        issue(DIV, 32'd12345, 32'd11);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {63'd0, busy}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("flush no done", 64'(pulses), 64'd0);
        chk("flush result kept", {32'd0, result}, {32'd0, old});
        run_check("mul 6*7 after flush", MUL, 32'd6, 32'd7);
        chk("mul 6*7 value", {32'd0, result}, 64'd42);

        // Start while busy with new operands: must be ignored.
        issue(DIVU, 32'd100, 32'd7);
        pulses = 0; old = 32'd0;
        for (int c = 1; c < 46; c++) begin
            start = (c >= 4 && c <= 20);
            aluc = {MUL[2:1], MUL[0], 3'b001}; a = 32'd555; b = 32'd2;
            if (done) begin pulses++; old = result; end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy start pulses", 64'(pulses), 64'd1);
        chk("busy start result", {32'd0, old}, 64'd14);

        // Reset in the middle of an operation.
        issue(MUL, 32'd123, 32'd456);
        repeat (14) @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("midreset busy", {63'd0, busy}, 64'd0);
        chk("midreset done", {63'd0, done}, 64'd0);
        chk("midreset result", {32'd0, result}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        run_check("rem after reset", REM, 32'hFFFF_FF00, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
